if_fetch_ctrl: RTL

Instruction-fetch controller for the OTTER 5-stage pipeline. It sits on the write side of the program counter register. It drives PC_WRITE/PC_DIN to advance or redirect the PC, issues synchronous instruction-memory reads at the current PC, and buffers returned instructions with their PCs in a small FIFO. Decode consumes the FIFO through a valid/ready handshake. Branch/jump redirects flush the buffer and squash the in-flight read.

---
 rtl/if_fetch_ctrl_if.sv | 41 ++++
 rtl/if_fetch_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_ctrl_if
//  Purpose  : Signal bundle between the instruction-fetch controller and its
//             surroundings (PC register, instruction memory, execute, decode).
//             master = fetch controller, slave = everything around it.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_ctrl_if #(
    parameter int XLEN = 32
);
    // program counter register
    logic [XLEN-1:0] PC_COUNT;
    logic            PC_WRITE;
    logic [XLEN-1:0] PC_DIN;
    // instruction memory (synchronous read, 1-cycle latency)
    logic            IMEM_RDEN;
    logic [XLEN-1:0] IMEM_ADDR;
    logic [XLEN-1:0] IMEM_DOUT;
    // redirect from execute
    logic            REDIRECT;
    logic [XLEN-1:0] REDIRECT_ADDR;
    // decode handshake
    logic            DEC_VALID;
    logic [XLEN-1:0] DEC_INSTR;
    logic [XLEN-1:0] DEC_PC;
    logic            DEC_READY;

    modport master (
        input  PC_COUNT, IMEM_DOUT, REDIRECT, REDIRECT_ADDR, DEC_READY,
        output PC_WRITE, PC_DIN, IMEM_RDEN, IMEM_ADDR,
               DEC_VALID, DEC_INSTR, DEC_PC
    );

    modport slave (
        output PC_COUNT, IMEM_DOUT, REDIRECT, REDIRECT_ADDR, DEC_READY,
        input  PC_WRITE, PC_DIN, IMEM_RDEN, IMEM_ADDR,
               DEC_VALID, DEC_INSTR, DEC_PC
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_ctrl
//  Purpose  : Instruction-fetch controller. Advances/redirects the PC, issues
//             synchronous instruction-memory reads at PC_COUNT and buffers the
//             returned {instr, pc} pairs in a DEPTH-entry FIFO for decode.
//             A redirect flushes the buffer and squashes the in-flight read.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  wire logic        CLK,
    input  wire logic        RST_N,
    if_fetch_ctrl_if.master  bus
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    // buffer storage and bookkeeping
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // one outstanding memory read
    logic            r_inflight_v;
    logic [XLEN-1:0] r_inflight_pc;

    logic            w_nonempty;
    logic            w_dec_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [c_CW:0]   w_occ;
    logic            w_unused_addr_lsbs;

    // The two low target bits are dropped: instructions are word aligned.
    assign w_unused_addr_lsbs = ^bus.REDIRECT_ADDR[1:0];

    // Handshake, credit check and issue decision. Reset gates the strobes so
    // they fall as soon as RST_N is asserted, without waiting for a clock.
    always_comb begin
        w_nonempty  = (r_count != '0);
        w_dec_valid = w_nonempty & ~bus.REDIRECT;
        w_pop       = w_dec_valid & bus.DEC_READY;
        w_push      = r_inflight_v & ~bus.REDIRECT;
        // entries that will be held (buffered + returning) after this pop
        w_occ       = {1'b0, r_count}
                    + (c_CW+1)'(r_inflight_v)
                    - (c_CW+1)'(w_pop);
        w_issue     = RST_N & ~bus.REDIRECT & (w_occ < (c_CW+1)'(DEPTH));
    end

    // Output drive: PC update, memory strobe and buffer head presentation.
    always_comb begin
        bus.IMEM_ADDR = bus.PC_COUNT;
        bus.IMEM_RDEN = w_issue;
        bus.PC_WRITE  = RST_N & (bus.REDIRECT | w_issue);
        if (bus.REDIRECT) begin
            bus.PC_DIN = {bus.REDIRECT_ADDR[XLEN-1:2], 2'b00};
        end else begin
            bus.PC_DIN = bus.PC_COUNT + XLEN'(4);
        end
        bus.DEC_VALID = w_dec_valid;
        if (w_nonempty) begin
            bus.DEC_INSTR = r_instr_mem[r_rd_ptr];
            bus.DEC_PC    = r_pc_mem[r_rd_ptr];
        end else begin
            bus.DEC_INSTR = '0;
            bus.DEC_PC    = '0;
        end
    end

    // Track the outstanding read; a redirect cancels it and blocks new issue.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_inflight_v  <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight_v <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= bus.PC_COUNT;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.REDIRECT) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // Buffer payload; contents are only observed through the count, so no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= bus.IMEM_DOUT;
            r_pc_mem[r_wr_ptr]    <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire
